// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (IF) and load/store (LS).
// Define MEM_ARB_FAIR_EN to enable the IF anti-starvation guard; otherwise LS has strict priority.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int BIT_WIDTH    = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_req,
    input  logic [ADDR_WIDTH-1:0]  if_addr,
    output logic                   if_gnt,
    output logic                   if_done,
    output logic [BIT_WIDTH-1:0]   if_rdata,
    input  logic                   ls_req,
    input  logic                   ls_we,
    input  logic [ADDR_WIDTH-1:0]  ls_addr,
    input  logic [BIT_WIDTH-1:0]   ls_wdata,
    input  logic [BIT_WIDTH/8-1:0] ls_be,
    output logic                   ls_gnt,
    output logic                   ls_done,
    output logic [BIT_WIDTH-1:0]   ls_rdata,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [BIT_WIDTH-1:0]   mem_wdata,
    output logic [BIT_WIDTH/8-1:0] mem_be,
    input  logic [BIT_WIDTH-1:0]   mem_rdata
);

    // state | meaning
    // IDLE  | no access in flight, grant allowed
    // WAIT  | access issued, counting down memory latency
    // RESP  | done pulse for finished access, new grant allowed
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_INIT   = 4'(MEM_LATENCY);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_lat
        $error("mem_port_arbiter: MEM_LATENCY out of range 1..15");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || STARVE_MAX == 4'd0) begin : g_bad_starve
        $error("mem_port_arbiter: STARVE_LIMIT out of range 1..15");
    end
    if (BIT_WIDTH % 8 != 0) begin : g_bad_width
        $error("mem_port_arbiter: BIT_WIDTH must be a multiple of 8");
    end

    state_t     state;
    logic [3:0] lat_cnt;
    logic       owner_ls;
    logic       owner_st;
    logic       can_grant;
    logic       force_if;

`ifdef MEM_ARB_FAIR_EN
    logic [3:0] starve_cnt;

    assign force_if = if_req && (starve_cnt == STARVE_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (if_gnt) begin
            starve_cnt <= '0;
        end else if (ls_gnt && if_req && (starve_cnt != STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    assign force_if = 1'b0;
`endif

    // Reset gates the grant path so nothing is accepted while rst is low.
    assign can_grant = rst && ((state == IDLE) || (state == RESP));
    assign ls_gnt    = can_grant && ls_req && !force_if;
    assign if_gnt    = can_grant && if_req && !ls_gnt;
    assign mem_en    = ls_gnt || if_gnt;
    assign mem_we    = ls_gnt && ls_we;
    assign mem_be    = mem_we ? ls_be : '0;
    assign mem_addr  = ls_gnt ? ls_addr : if_addr;
    assign mem_wdata = ls_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            lat_cnt  <= '0;
            owner_ls <= 1'b0;
            owner_st <= 1'b0;
            if_done  <= 1'b0;
            ls_done  <= 1'b0;
            if_rdata <= '0;
            ls_rdata <= '0;
        end else begin
            if_done <= 1'b0;
            ls_done <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (mem_en) begin
                        state    <= WAIT;
                        lat_cnt  <= LAT_INIT;
                        owner_ls <= ls_gnt;
                        owner_st <= mem_we;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (lat_cnt == 4'd1) begin
                        lat_cnt <= '0;
                        state   <= RESP;
                        if (owner_ls) begin
                            ls_done <= 1'b1;
                            if (!owner_st) begin
                                ls_rdata <= mem_rdata;
                            end
                        end else begin
                            if_done  <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
